execute_stage: RTL and testbench

- Pipeline stage directly downstream of decode. Consumes the registered operands, ALU opcode, bypass selects, destination and branch target.
- Resolves operand forwarding from its own result register and computes ADD, SUB and MUL (iterative, multi-cycle) plus JALR and BEQ.
- Produces the registered result for writeback, and a redirect, kill and stall back to fetch/decode.

---
 rtl/execute_stage_pkg.sv | 31 +++
 rtl/execute_stage_multiplier.sv | 101 ++++++++++
 rtl/execute_stage.sv | 130 +++++++++++++
 tb/tb_execute_stage.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/execute_stage_pkg.sv
// Shared constants for the execute stage: ALU opcodes, bypass selects,
// boolean and RISC-V register constants, plus the operand-forwarding helper.
package execute_stage_pkg;

    // ALU opcodes as driven by decode.
    localparam logic [4:0] ADDITION       = 5'd0;
    localparam logic [4:0] SUBTRACTION    = 5'd1;
    localparam logic [4:0] MULTIPLICATION = 5'd2;
    localparam logic [4:0] UNCOND_JUMP    = 5'd3;
    localparam logic [4:0] COND_EQ_JUMP   = 5'd4;

    // Operand bypass selects.
    localparam logic [3:0] NO_BYPASS       = 4'd0;
    localparam logic [3:0] BYPASS_FROM_ALU = 4'd1;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    // RISC-V constants.
    localparam logic [4:0]  REG_X0    = 5'd0;
    localparam logic [31:0] ZERO_WORD = 32'd0;
    localparam int unsigned XLEN      = 32;

    // Any select other than BYPASS_FROM_ALU falls back to the decoded value.
    function automatic logic [31:0] select_operand(input logic [3:0]  bypass,
                                                   input logic [31:0] forwarded,
                                                   input logic [31:0] decoded);
        return (bypass == BYPASS_FROM_ALU) ? forwarded : decoded;
    endfunction

endpackage

// File: rtl/execute_stage_multiplier.sv
// iterative_multiplier: 32x32 -> low 32 bits, MUL_BITS_PER_CYCLE multiplier
// bits per cycle, N = 32/MUL_BITS_PER_CYCLE cycles in total.
//   clk, reset     : clock, asynchronous active-high reset (aborts a multiply)
//   start          : request a multiply; only honoured while idle
//   a, b           : multiplicand, multiplier (sampled with start)
//   busy           : in the BUSY state (cycles 2..N of a multiply)
//   done           : combinational, product valid this cycle (final cycle)
//   product[31:0]  : combinational result, meaningful while done is high
module iterative_multiplier
    import execute_stage_pkg::*;
#(
    parameter int unsigned MUL_BITS_PER_CYCLE = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] product
);

    localparam int unsigned K          = MUL_BITS_PER_CYCLE;
    localparam int unsigned NUM_CYCLES = XLEN / K;
    localparam logic [31:0] DIGIT_MASK = (K >= 32) ? 32'hFFFF_FFFF
                                                   : 32'((64'd1 << K) - 64'd1);

    localparam logic MUL_IDLE = 1'b0;
    localparam logic MUL_BUSY = 1'b1;

    logic        state_q, state_d;
    logic [5:0]  count_q, count_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] mcand_q, mcand_d;   // multiplicand pre-shifted to the next digit
    logic [31:0] mplier_q, mplier_d; // remaining multiplier digits, next in the low K bits

    logic [31:0] first_partial;
    logic [31:0] step_partial;

    // The start cycle already consumes digit 0, so N-1 BUSY cycles cover the rest.
    assign first_partial = a * (b & DIGIT_MASK);
    assign step_partial  = mcand_q * (mplier_q & DIGIT_MASK);
    assign busy          = (state_q == MUL_BUSY);

    always_comb begin
        if (NUM_CYCLES == 1) begin
            done    = start;
            product = first_partial;
        end else begin
            done    = busy && (count_q == 6'd1);
            product = acc_q + step_partial;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        unique case (state_q)
            MUL_IDLE: begin
                if (start && (NUM_CYCLES > 1)) begin
                    state_d  = MUL_BUSY;
                    count_d  = 6'(NUM_CYCLES - 1);
                    acc_d    = first_partial;
                    mcand_d  = a << K;
                    mplier_d = b >> K;
                end
            end
            MUL_BUSY: begin
                acc_d    = acc_q + step_partial;
                mcand_d  = mcand_q << K;
                mplier_d = mplier_q >> K;
                count_d  = count_q - 6'd1;
                if (count_q == 6'd1) begin
                    state_d = MUL_IDLE;
                end
            end
            default: state_d = MUL_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= MUL_IDLE;
            count_q  <= 6'd0;
            acc_q    <= ZERO_WORD;
            mcand_q  <= ZERO_WORD;
            mplier_q <= ZERO_WORD;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end

endmodule

// File: rtl/execute_stage.sv
// execute_stage: operand forwarding, ADD/SUB/MUL/JALR/BEQ execution.
//   clk, reset                           : clock, asynchronous active-high reset
//   operand1, operand2                   : decoded rs1 / rs2-or-immediate
//   alu_operation                        : ALU opcode
//   bypass1, bypass2                     : forwarding selects for each operand
//   dest_register_enable/number          : rd write enable and index
//   passthrough_next_program_counter     : link value (PC+4)
//   branch_dest                          : BEQ target
//   alu_result, result_dest_enable/number: registered writeback
//   redirect_valid, redirect_pc          : combinational taken jump/branch
//   kill_instr                           : squash the instruction in decode
//   stall                                : hold fetch/decode
module execute_stage
    import execute_stage_pkg::*;
#(
    parameter int unsigned MUL_BITS_PER_CYCLE = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] operand1,
    input  logic [31:0] operand2,
    input  logic [4:0]  alu_operation,
    input  logic [3:0]  bypass1,
    input  logic [3:0]  bypass2,
    input  logic        dest_register_enable,
    input  logic [4:0]  dest_register_number,
    input  logic [31:0] passthrough_next_program_counter,
    input  logic [31:0] branch_dest,
    output logic [31:0] alu_result,
    output logic        result_dest_enable,
    output logic [4:0]  result_dest_number,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        kill_instr,
    output logic        stall
);

    localparam int unsigned MUL_CYCLES      = XLEN / MUL_BITS_PER_CYCLE;
    localparam logic        MUL_MULTI_CYCLE = (MUL_CYCLES > 1);

    logic [31:0] a, b;
    logic [31:0] sum, single_result;
    logic        is_mul, mul_start, mul_busy, mul_done;
    logic [31:0] mul_product;
    logic        dest_enable_eff;
    logic        mul_dest_enable_q;
    logic [4:0]  mul_dest_number_q;

    assign a = select_operand(bypass1, alu_result, operand1);
    assign b = select_operand(bypass2, alu_result, operand2);

    assign sum             = a + b;
    assign is_mul          = (alu_operation == MULTIPLICATION);
    assign mul_start       = is_mul && !mul_busy;
    assign dest_enable_eff = dest_register_enable && (dest_register_number != REG_X0);

    iterative_multiplier #(
        .MUL_BITS_PER_CYCLE(MUL_BITS_PER_CYCLE)
    ) u_multiplier (
        .clk    (clk),
        .reset  (reset),
        .start  (mul_start),
        .a      (a),
        .b      (b),
        .busy   (mul_busy),
        .done   (mul_done),
        .product(mul_product)
    );

    // BEQ result is don't-care; it falls into the ADD default.
    always_comb begin
        case (alu_operation)
            SUBTRACTION: single_result = a - b;
            UNCOND_JUMP: single_result = passthrough_next_program_counter;
            default:     single_result = sum;
        endcase
    end

    always_comb begin
        redirect_valid = FALSE;
        redirect_pc    = ZERO_WORD;
        if (!mul_busy) begin
            if (alu_operation == UNCOND_JUMP) begin
                redirect_valid = TRUE;
                redirect_pc    = sum & ~32'd1;
            end else if (alu_operation == COND_EQ_JUMP) begin
                redirect_valid = (a == b);
                redirect_pc    = branch_dest;
            end
        end
    end

    assign kill_instr = redirect_valid;

    // Stall drops in the final MUL cycle so the dependent instruction can
    // enter next cycle and pick up the product via BYPASS_FROM_ALU.
    assign stall = (mul_start && MUL_MULTI_CYCLE) || (mul_busy && !mul_done);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_result         <= ZERO_WORD;
            result_dest_enable <= FALSE;
            result_dest_number <= REG_X0;
            mul_dest_enable_q  <= FALSE;
            mul_dest_number_q  <= REG_X0;
        end else if (mul_busy) begin
            if (mul_done) begin
                alu_result         <= mul_product;
                result_dest_enable <= mul_dest_enable_q;
                result_dest_number <= mul_dest_number_q;
            end else begin
                result_dest_enable <= FALSE;
            end
        end else if (is_mul && !MUL_MULTI_CYCLE) begin
            alu_result         <= mul_product;
            result_dest_enable <= dest_enable_eff;
            result_dest_number <= dest_register_number;
        end else if (is_mul) begin
            // Capture edge: bubble, and remember rd for the final edge.
            result_dest_enable <= FALSE;
            mul_dest_enable_q  <= dest_enable_eff;
            mul_dest_number_q  <= dest_register_number;
        end else begin
            alu_result         <= single_result;
            result_dest_enable <= dest_enable_eff;
            result_dest_number <= dest_register_number;
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage with a spec-level model checked every cycle.
module tb_execute_stage;
    import execute_stage_pkg::*;

    localparam int unsigned BITS = 8;
    localparam int unsigned NCYC = 32 / BITS;

    logic        clk;
    logic        reset;
    logic [31:0] operand1, operand2;
    logic [4:0]  alu_operation;
    logic [3:0]  bypass1, bypass2;
    logic        dest_register_enable;
    logic [4:0]  dest_register_number;
    logic [31:0] passthrough_next_program_counter, branch_dest;
    logic [31:0] alu_result;
    logic        result_dest_enable;
    logic [4:0]  result_dest_number;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        kill_instr;
    logic        stall;

    int checks = 0;
    int errors = 0;

    execute_stage #(
        .MUL_BITS_PER_CYCLE(BITS)
    ) dut (
        .clk                             (clk),
        .reset                           (reset),
        .operand1                        (operand1),
        .operand2                        (operand2),
        .alu_operation                   (alu_operation),
        .bypass1                         (bypass1),
        .bypass2                         (bypass2),
        .dest_register_enable            (dest_register_enable),
        .dest_register_number            (dest_register_number),
        .passthrough_next_program_counter(passthrough_next_program_counter),
        .branch_dest                     (branch_dest),
        .alu_result                      (alu_result),
        .result_dest_enable              (result_dest_enable),
        .result_dest_number              (result_dest_number),
        .redirect_valid                  (redirect_valid),
        .redirect_pc                     (redirect_pc),
        .kill_instr                      (kill_instr),
        .stall                           (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_result = 32'd0;
    logic        m_known  = 1'b1;    // alu_result is defined (not after a BEQ)
    logic        m_en     = 1'b0;
    logic [4:0]  m_num    = 5'd0;
    int          m_left   = 0;       // MUL cycles still to run after this one
    logic [31:0] m_prod   = 32'd0;
    logic        m_pen    = 1'b0;
    logic [4:0]  m_pnum   = 5'd0;

    function automatic logic [31:0] eff(input logic [3:0] sel, input logic [31:0] v);
        return (sel == BYPASS_FROM_ALU) ? m_result : v;
    endfunction

    always @(posedge clk or posedge reset) begin
        logic [31:0] ma, mb;
        logic        wen;
        if (reset) begin
            m_result = 32'd0; m_known = 1'b1; m_en = 1'b0; m_num = 5'd0; m_left = 0;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_result = m_prod; m_known = 1'b1; m_en = m_pen; m_num = m_pnum;
            end else begin
                m_en = 1'b0;
            end
        end else begin
            ma  = eff(bypass1, operand1);
            mb  = eff(bypass2, operand2);
            wen = dest_register_enable && (dest_register_number != 5'd0);
            if (alu_operation == MULTIPLICATION) begin
                m_prod = ma * mb; m_pen = wen; m_pnum = dest_register_number;
                if (NCYC == 1) begin
                    m_result = m_prod; m_known = 1'b1; m_en = wen;
                    m_num = dest_register_number;
                end else begin
                    m_left = NCYC - 1; m_en = 1'b0;
                end
            end else begin
                m_known = 1'b1;
                if (alu_operation == SUBTRACTION) m_result = ma - mb;
                else if (alu_operation == UNCOND_JUMP)
                    m_result = passthrough_next_program_counter;
                else if (alu_operation == COND_EQ_JUMP) m_known = 1'b0;
                else m_result = ma + mb;
                m_en = wen; m_num = dest_register_number;
            end
        end
    end

    // Compare 1 time unit before each rising edge.
    always @(negedge clk) begin
        logic [31:0] ea, eb, epc;
        logic        estall, eredir;
        #4;
        ea     = eff(bypass1, operand1);
        eb     = eff(bypass2, operand2);
        estall = (m_left == 0) ? (alu_operation == MULTIPLICATION && NCYC > 1) : (m_left > 1);
        eredir = (m_left == 0) && ((alu_operation == UNCOND_JUMP) ||
                 (alu_operation == COND_EQ_JUMP && ea == eb));
        epc    = (alu_operation == UNCOND_JUMP) ? ((ea + eb) & 32'hFFFF_FFFE) : branch_dest;
        check("cmp_stall", {31'd0, stall}, {31'd0, estall});
        check("cmp_redirect", {31'd0, redirect_valid}, {31'd0, eredir});
        check("cmp_kill", {31'd0, kill_instr}, {31'd0, eredir});
        if (eredir) check("cmp_redirect_pc", redirect_pc, epc);
        check("cmp_dest_en", {31'd0, result_dest_enable}, {31'd0, m_en});
        if (m_en) check("cmp_dest_num", {27'd0, result_dest_number}, {27'd0, m_num});
        if (m_known) check("cmp_result", alu_result, m_result);
    end

    // ---------------- directed stimulus ----------------
    task automatic set_in(input logic [4:0] op, input logic [31:0] o1, input logic [31:0] o2,
                          input logic [3:0] b1, input logic [3:0] b2, input logic en,
                          input logic [4:0] rd, input logic [31:0] link,
                          input logic [31:0] bdest);
        alu_operation = op; operand1 = o1; operand2 = o2; bypass1 = b1; bypass2 = b2;
        dest_register_enable = en; dest_register_number = rd;
        passthrough_next_program_counter = link; branch_dest = bdest;
    endtask

    task automatic drive(input logic [4:0] op, input logic [31:0] o1, input logic [31:0] o2,
                         input logic [3:0] b1, input logic [3:0] b2, input logic en,
                         input logic [4:0] rd, input logic [31:0] link,
                         input logic [31:0] bdest);
        @(negedge clk);
        #1;
        set_in(op, o1, o2, b1, b2, en, rd, link, bdest);
        #1;
    endtask

    task automatic nop();
        drive(ADDITION, 0, 0, NO_BYPASS, NO_BYPASS, 1'b0, 5'd0, 0, 0);
    endtask

    initial begin
        reset = 1'b0;
        set_in(ADDITION, 0, 0, NO_BYPASS, NO_BYPASS, 1'b0, 5'd0, 0, 0);
        #1 reset = 1'b1;
        nop();
        nop();
        check("reset_result", alu_result, 32'd0);
        check("reset_dest_en", {31'd0, result_dest_enable}, 32'd0);
        check("reset_dest_num", {27'd0, result_dest_number}, 32'd0);
        check("reset_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        #1 reset = 1'b0;

        drive(ADDITION, 5, 7, NO_BYPASS, NO_BYPASS, 1'b1, 5'd3, 0, 0);
        drive(SUBTRACTION, 3, 5, NO_BYPASS, NO_BYPASS, 1'b1, 5'd4, 0, 0);
        check("add_result", alu_result, 32'd12);
        check("add_dest_en", {31'd0, result_dest_enable}, 32'd1);
        check("add_dest_num", {27'd0, result_dest_number}, 32'd3);
        drive(ADDITION, 0, 1, BYPASS_FROM_ALU, NO_BYPASS, 1'b1, 5'd5, 0, 0);
        check("sub_result", alu_result, 32'hFFFF_FFFE);
        drive(ADDITION, 1, 1, NO_BYPASS, NO_BYPASS, 1'b1, 5'd0, 0, 0);
        check("bypass_result", alu_result, 32'hFFFF_FFFF);
        nop();
        check("x0_dest_en", {31'd0, result_dest_enable}, 32'd0);
        check("x0_result", alu_result, 32'd2);

        // Forward from a result of 12, with a stale operand1.
        drive(ADDITION, 6, 6, NO_BYPASS, NO_BYPASS, 1'b1, 5'd3, 0, 0);
        drive(ADDITION, 0, 1, BYPASS_FROM_ALU, NO_BYPASS, 1'b1, 5'd5, 0, 0);
        nop();
        check("bypass12_result", alu_result, 32'd13);

        // MUL, held at the inputs while stalled.
        for (int i = 0; i < int'(NCYC); i++) begin
            drive(MULTIPLICATION, 32'h0001_0000, 32'h0001_0003, NO_BYPASS, NO_BYPASS,
                  1'b1, 5'd6, 0, 0);
            check($sformatf("mul_stall_c%0d", i + 1), {31'd0, stall},
                  {31'd0, (i < int'(NCYC) - 1)});
            if (i > 0) check($sformatf("mul_bubble_c%0d", i + 1),
                             {31'd0, result_dest_enable}, 32'd0);
        end
        drive(ADDITION, 0, 1, BYPASS_FROM_ALU, NO_BYPASS, 1'b1, 5'd7, 0, 0);
        check("mul_result", alu_result, 32'h0003_0000);
        check("mul_dest_en", {31'd0, result_dest_enable}, 32'd1);
        check("mul_dest_num", {27'd0, result_dest_number}, 32'd6);
        nop();
        check("mul_dep_result", alu_result, 32'h0003_0001);

        drive(COND_EQ_JUMP, 9, 9, NO_BYPASS, NO_BYPASS, 1'b0, 5'd0, 0, 32'h40);
        check("beq_taken", {31'd0, redirect_valid}, 32'd1);
        check("beq_kill", {31'd0, kill_instr}, 32'd1);
        check("beq_pc", redirect_pc, 32'h40);
        drive(COND_EQ_JUMP, 9, 8, NO_BYPASS, NO_BYPASS, 1'b0, 5'd0, 0, 32'h40);
        check("beq_not_taken", {31'd0, redirect_valid}, 32'd0);

        drive(UNCOND_JUMP, 32'h101, 4, NO_BYPASS, NO_BYPASS, 1'b1, 5'd1, 32'h24, 0);
        check("jalr_redirect", {31'd0, redirect_valid}, 32'd1);
        check("jalr_pc", redirect_pc, 32'h104);
        nop();
        check("jalr_link", alu_result, 32'h24);

        // Reset during the second MUL cycle.
        drive(ADDITION, 32'h55, 0, NO_BYPASS, NO_BYPASS, 1'b1, 5'd2, 0, 0);
        drive(MULTIPLICATION, 3, 5, NO_BYPASS, NO_BYPASS, 1'b1, 5'd8, 0, 0);
        drive(MULTIPLICATION, 3, 5, NO_BYPASS, NO_BYPASS, 1'b1, 5'd8, 0, 0);
        check("pre_reset_stall", {31'd0, stall}, 32'd1);
        check("pre_reset_held", alu_result, 32'h55);
        reset = 1'b1;
        set_in(ADDITION, 0, 0, NO_BYPASS, NO_BYPASS, 1'b0, 5'd0, 0, 0);
        #1;
        check("midmul_reset_result", alu_result, 32'd0);
        check("midmul_reset_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < int'(NCYC) + 1; i++) begin
            nop();
            check($sformatf("post_reset_no_wb_%0d", i), {31'd0, result_dest_enable}, 32'd0);
            check($sformatf("post_reset_stall_%0d", i), {31'd0, stall}, 32'd0);
        end
        drive(ADDITION, 2, 3, NO_BYPASS, NO_BYPASS, 1'b1, 5'd9, 0, 0);
        nop();
        check("post_reset_add", alu_result, 32'd5);
        check("post_reset_dest_num", {27'd0, result_dest_number}, 32'd9);
        nop();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
